// File: rtl/exu2lsu.sv
// EXU -> LSU pipeline stage: two-entry skid buffer with registered ready,
// synchronous flush and a saturating LSU stall-cycle counter.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ARGS_WIDTH
`define ARGS_WIDTH 8
`endif
`ifndef GPRS_WIDTH
`define GPRS_WIDTH 5
`endif
`ifndef ADDR_INIT
`define ADDR_INIT {`ADDR_WIDTH{1'b0}}
`endif
`ifndef INST_NAME_X
`define INST_NAME_X {`ARGS_WIDTH{1'b0}}
`endif
`ifndef RAM_BYT_X
`define RAM_BYT_X {`ARGS_WIDTH{1'b0}}
`endif
`ifndef REG_WR_SRC_X
`define REG_WR_SRC_X {`ARGS_WIDTH{1'b0}}
`endif
`ifndef DATA_ZERO
`define DATA_ZERO {`DATA_WIDTH{1'b0}}
`endif
`ifndef GPRS_ZERO
`define GPRS_ZERO {`GPRS_WIDTH{1'b0}}
`endif

module exu2lsu (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_rst,
  input  logic                   i_exu_valid,
  output logic                   o_e2l_ready,
  output logic                   o_e2l_valid,
  input  logic                   i_lsu_ready,
  input  logic                   i_flush,
  input  logic [`ADDR_WIDTH-1:0] i_exu_pc,
  input  logic [`ARGS_WIDTH-1:0] i_exu_ctr_inst_name,
  input  logic                   i_exu_ctr_ram_wr_en,
  input  logic [`ARGS_WIDTH-1:0] i_exu_ctr_ram_byt,
  input  logic                   i_exu_ctr_reg_wr_en,
  input  logic [`ARGS_WIDTH-1:0] i_exu_ctr_reg_wr_src,
  input  logic [`DATA_WIDTH-1:0] i_exu_alu_res,
  input  logic [`DATA_WIDTH-1:0] i_exu_rs2_data,
  input  logic [`GPRS_WIDTH-1:0] i_exu_gpr_rd_id,
  input  logic [`DATA_WIDTH-1:0] i_exu_jmp_or_reg_data,
  output logic [`ADDR_WIDTH-1:0] o_e2l_pc,
  output logic [`ARGS_WIDTH-1:0] o_e2l_ctr_inst_name,
  output logic                   o_e2l_ctr_ram_wr_en,
  output logic [`ARGS_WIDTH-1:0] o_e2l_ctr_ram_byt,
  output logic                   o_e2l_ctr_reg_wr_en,
  output logic [`ARGS_WIDTH-1:0] o_e2l_ctr_reg_wr_src,
  output logic [`DATA_WIDTH-1:0] o_e2l_alu_res,
  output logic [`DATA_WIDTH-1:0] o_e2l_rs2_data,
  output logic [`GPRS_WIDTH-1:0] o_e2l_gpr_rd_id,
  output logic [`DATA_WIDTH-1:0] o_e2l_jmp_or_reg_data,
  output logic [15:0]            o_e2l_stall_cnt
);

  typedef struct packed {
    logic [`ADDR_WIDTH-1:0] pc;
    logic [`ARGS_WIDTH-1:0] inst_name;
    logic                   ram_wr_en;
    logic [`ARGS_WIDTH-1:0] ram_byt;
    logic                   reg_wr_en;
    logic [`ARGS_WIDTH-1:0] reg_wr_src;
    logic [`DATA_WIDTH-1:0] alu_res;
    logic [`DATA_WIDTH-1:0] rs2_data;
    logic [`GPRS_WIDTH-1:0] rd_id;
    logic [`DATA_WIDTH-1:0] jmp_or_reg_data;
  } payload_t;

  localparam payload_t PAYLOAD_RST = '{
    pc:              `ADDR_INIT,
    inst_name:       `INST_NAME_X,
    ram_wr_en:       1'b0,
    ram_byt:         `RAM_BYT_X,
    reg_wr_en:       1'b0,
    reg_wr_src:      `REG_WR_SRC_X,
    alu_res:         `DATA_ZERO,
    rs2_data:        `DATA_ZERO,
    rd_id:           `GPRS_ZERO,
    jmp_or_reg_data: `DATA_ZERO
  };

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  payload_t    main_q, main_d;
  payload_t    skid_q, skid_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  payload_t    in_pl;
  logic        push;
  logic        pop;

  assign in_pl = '{
    pc:              i_exu_pc,
    inst_name:       i_exu_ctr_inst_name,
    ram_wr_en:       i_exu_ctr_ram_wr_en,
    ram_byt:         i_exu_ctr_ram_byt,
    reg_wr_en:       i_exu_ctr_reg_wr_en,
    reg_wr_src:      i_exu_ctr_reg_wr_src,
    alu_res:         i_exu_alu_res,
    rs2_data:        i_exu_rs2_data,
    rd_id:           i_exu_gpr_rd_id,
    jmp_or_reg_data: i_exu_jmp_or_reg_data
  };

  // Both handshake flags decode the state flop only, so ready is registered.
  assign o_e2l_valid = (state_q != ST_EMPTY);
  assign o_e2l_ready = (state_q != ST_FULL);
  assign push        = i_exu_valid & o_e2l_ready;
  assign pop         = o_e2l_valid & i_lsu_ready;

  always_comb begin
    // NOTE: every next-state value is defaulted to hold first, so no path can infer a latch.
    state_d     = state_q;
    main_d      = main_q;
    skid_d      = skid_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          main_d  = in_pl;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          main_d = in_pl;
        end else if (push) begin
          skid_d  = in_pl;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    // Flush clears occupancy only; payload may be left stale.
    if (i_flush) state_d = ST_EMPTY;

    if (o_e2l_valid && !i_lsu_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  // NOTE: payload registers are reset too, because the outputs have defined reset values.
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      state_q     <= ST_EMPTY;
      main_q      <= PAYLOAD_RST;
      skid_q      <= PAYLOAD_RST;
      stall_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_e2l_pc              = main_q.pc;
  assign o_e2l_ctr_inst_name   = main_q.inst_name;
  assign o_e2l_ctr_ram_wr_en   = main_q.ram_wr_en;
  assign o_e2l_ctr_ram_byt     = main_q.ram_byt;
  assign o_e2l_ctr_reg_wr_en   = main_q.reg_wr_en;
  assign o_e2l_ctr_reg_wr_src  = main_q.reg_wr_src;
  assign o_e2l_alu_res         = main_q.alu_res;
  assign o_e2l_rs2_data        = main_q.rs2_data;
  assign o_e2l_gpr_rd_id       = main_q.rd_id;
  assign o_e2l_jmp_or_reg_data = main_q.jmp_or_reg_data;
  assign o_e2l_stall_cnt       = stall_cnt_q;

endmodule
